// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared types and constants for the multicycle MIPS control
//               unit: FSM state encoding, opcode / funct field values and
//               3-bit ALU operation codes, plus the R-type funct decoder.
// Optional    : BNE_EN (BNEEX state is always declared; it is only reachable
//               when the macro is defined in the top module).
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } statetype_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  // Idle code for states that do not use the ALU (same bits as AND)
  localparam logic [2:0] ALU_NONE = 3'b000;

  // Unknown funct values fall back to add so a stray encoding still
  // produces a deterministic result instead of a random operation.
  function automatic logic [2:0] rtype_alu(input logic [5:0] funct);
    logic [2:0] alu;
    case (funct)
      FN_ADD:  alu = ALU_ADD;
      FN_SUB:  alu = ALU_SUB;
      FN_AND:  alu = ALU_AND;
      FN_OR:   alu = ALU_OR;
      FN_SLT:  alu = ALU_SLT;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_aludec.sv
`default_nettype none
// ============================================================================
// Module      : mc_aludec
// Description : Combinational ALU decoder. Maps the controller state plus the
//               instruction op/funct fields onto a 3-bit ALU operation.
// Ports       : i_state  - current controller state
//               i_op     - IR[31:26]
//               i_funct  - IR[5:0]
//               o_alu    - ALU operation code
// Revision    : 1.0 - initial release
// ============================================================================
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  statetype_e  i_state,
  input  logic [5:0]  i_op,
  input  logic [5:0]  i_funct,
  output logic [2:0]  o_alu
);

  always_comb begin
    o_alu = ALU_NONE;
    case (i_state)
      // PC+4 in FETCH, branch target in DECODE, address in MEMADR
      FETCH, DECODE, MEMADR: o_alu = ALU_ADD;
      RTYPEEX:               o_alu = rtype_alu(i_funct);
      BEQEX, BNEEX:          o_alu = ALU_SUB;
      IMMEX: begin
        case (i_op)
          OP_ANDI: o_alu = ALU_AND;
          OP_ORI:  o_alu = ALU_OR;
          default: o_alu = ALU_ADD;
        endcase
      end
      default:               o_alu = ALU_NONE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Moore-style control FSM for a multicycle MIPS datapath with a
//               memory ready handshake, retired-instruction counter and
//               illegal-opcode pulse.
// Optional    : define BNE_EN to add the bne instruction (state BNEEX);
//               without it op 000101 is treated as illegal.
// Parameters  : ALUCTRL_W (>=3) alucontrol width, upper bits driven 0
//               CNT_W     retired_count width
// Ports       : clk, reset_n (async, active-low)
//               op, funct, zero, mem_ready          - inputs
//               iord..pcen                          - datapath controls
//               illegal_op                          - undefined-op pulse
//               retired_count                       - completed instructions
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 zeroext,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     retired_count
);

  statetype_e       r_state;
  statetype_e       w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_illegal;

  logic       w_iord, w_memread, w_memwrite, w_irwrite;
  logic       w_regdst, w_memtoreg, w_regwrite, w_alusrca;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic       w_zeroext, w_pcen;
  logic [2:0] w_alu;
  logic [2:0] w_alu_gated;

  // --------------------------------------------------------------------------
  // Next state, retire and illegal-op detection
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      FETCH: begin
        if (mem_ready) w_next = DECODE;
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW:            w_next = MEMADR;
          OP_RTYPE:                w_next = RTYPEEX;
          OP_BEQ:                  w_next = BEQEX;
          OP_ADDI, OP_ANDI, OP_ORI: w_next = IMMEX;
          OP_J:                    w_next = JEX;
`ifdef BNE_EN
          OP_BNE:                  w_next = BNEEX;
`endif
          default: begin
            // Undefined op: abandon the instruction without retiring it
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR:  w_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (mem_ready) w_next = MEMWB;
      end
      MEMWR: begin
        if (mem_ready) begin
          w_next   = FETCH;
          w_retire = 1'b1;
        end
      end
      RTYPEEX: w_next = RTYPEWB;
      IMMEX:   w_next = IMMWB;
      MEMWB, RTYPEWB, BEQEX, BNEEX, IMMWB, JEX: begin
        w_next   = FETCH;
        w_retire = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Control decode from state (zero / mem_ready only affect pcen, irwrite)
  // --------------------------------------------------------------------------
  always_comb begin
    w_iord     = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_zeroext  = 1'b0;
    w_pcsrc    = 2'b00;
    w_pcen     = 1'b0;
    case (r_state)
      FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        // IR and PC update only once the instruction word has arrived
        w_irwrite = mem_ready;
        w_pcen    = mem_ready;
      end
      DECODE:  w_alusrcb = 2'b11;
      MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      MEMRD: begin
        w_iord    = 1'b1;
        w_memread = 1'b1;
      end
      MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      RTYPEEX: w_alusrca = 1'b1;
      RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      BEQEX: begin
        w_alusrca = 1'b1;
        w_pcsrc   = 2'b01;
        w_pcen    = zero;
      end
      BNEEX: begin
        w_alusrca = 1'b1;
        w_pcsrc   = 2'b01;
        w_pcen    = ~zero;
      end
      IMMEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        // Logical immediates are zero-extended, addi is sign-extended
        w_zeroext = (op == OP_ANDI) || (op == OP_ORI);
      end
      IMMWB:   w_regwrite = 1'b1;
      JEX: begin
        w_pcsrc = 2'b10;
        w_pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .i_state (r_state),
    .i_op    (op),
    .i_funct (funct),
    .o_alu   (w_alu)
  );

  // --------------------------------------------------------------------------
  // Outputs: the state register resets to FETCH, whose decode is not all
  // zero, so every output is also gated by reset_n to keep the datapath
  // quiet (no strobe, no write) for the whole time reset is asserted.
  // --------------------------------------------------------------------------
  assign iord          = reset_n & w_iord;
  assign memread       = reset_n & w_memread;
  assign memwrite      = reset_n & w_memwrite;
  assign irwrite       = reset_n & w_irwrite;
  assign regdst        = reset_n & w_regdst;
  assign memtoreg      = reset_n & w_memtoreg;
  assign regwrite      = reset_n & w_regwrite;
  assign alusrca       = reset_n & w_alusrca;
  assign alusrcb       = reset_n ? w_alusrcb : 2'b00;
  assign zeroext       = reset_n & w_zeroext;
  assign pcsrc         = reset_n ? w_pcsrc : 2'b00;
  assign pcen          = reset_n & w_pcen;
  assign illegal_op    = reset_n & w_illegal & (r_state == DECODE);
  assign retired_count = r_retired;
  assign w_alu_gated   = reset_n ? w_alu : 3'b000;

  generate
    if (ALUCTRL_W > 3) begin : g_alu_pad
      assign alucontrol = {{(ALUCTRL_W-3){1'b0}}, w_alu_gated};
    end else begin : g_alu_nopad
      assign alucontrol = w_alu_gated;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Scoreboard bench for multicycle_controller. Stimulus walks
//               each instruction through its cycle recipe, pushing the
//               expected control word and retired count per cycle; a monitor
//               pops and compares on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  localparam int AW = 4;
  localparam int CW = 4;

  // Instruction phases of the reference recipes
  localparam int P_RST = 0,  P_F  = 1,  P_D   = 2,  P_MA  = 3,  P_MR = 4;
  localparam int P_MWB = 5,  P_MW = 6,  P_RX  = 7,  P_RWB = 8,  P_BQ = 9;
  localparam int P_BN  = 10, P_IX = 11, P_IWB = 12, P_J   = 13;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [5:0]    op = '0, funct = '0;
  logic          zero = 1'b0, mem_ready = 1'b0;
  logic          iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic          alusrca, zeroext, pcen, illegal_op;
  logic [1:0]    alusrcb, pcsrc;
  logic [AW-1:0] alucontrol;
  logic [CW-1:0] retired_count;

  multicycle_controller #(.ALUCTRL_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .zeroext(zeroext), .alucontrol(alucontrol),
    .pcsrc(pcsrc), .pcen(pcen), .illegal_op(illegal_op),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  wire [18:0] act = {iord, memread, memwrite, irwrite, regdst, memtoreg,
                     regwrite, alusrca, alusrcb, zeroext, alucontrol, pcsrc,
                     pcen, illegal_op};

  typedef struct {
    int            ph;
    logic [18:0]   ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] m_cnt = '0;

  function automatic bit is_legal(input logic [5:0] o);
    bit ok;
    ok = o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                   6'b001000, 6'b001100, 6'b001101, 6'b000010};
`ifdef BNE_EN
    if (o == 6'b000101) ok = 1'b1;
`endif
    return ok;
  endfunction

  // Expected control word for one cycle of a phase, from the ISA table
  function automatic logic [18:0] exp_ctl(input int ph, input logic [5:0] o,
                                          input logic [5:0] f, input logic z,
                                          input logic mr);
    logic io, mrd, mwr, irw, rd, m2r, rw, sa, ze, pe, ill;
    logic [1:0] sb, ps;
    logic [3:0] alu;
    {io, mrd, mwr, irw, rd, m2r, rw, sa, ze, pe, ill} = '0;
    sb = 2'd0; ps = 2'd0; alu = 4'd0;
    case (ph)
      P_F:   begin mrd = 1; sb = 2'b01; alu = 4'b0010; irw = mr; pe = mr; end
      P_D:   begin sb = 2'b11; alu = 4'b0010; ill = !is_legal(o); end
      P_MA:  begin sa = 1; sb = 2'b10; alu = 4'b0010; end
      P_MR:  begin io = 1; mrd = 1; end
      P_MWB: begin m2r = 1; rw = 1; end
      P_MW:  begin io = 1; mwr = 1; end
      P_RX: begin
        sa = 1;
        case (f)
          6'b100010: alu = 4'b0110;
          6'b100100: alu = 4'b0000;
          6'b100101: alu = 4'b0001;
          6'b101010: alu = 4'b0111;
          default:   alu = 4'b0010;
        endcase
      end
      P_RWB: begin rd = 1; rw = 1; end
      P_BQ:  begin sa = 1; alu = 4'b0110; ps = 2'b01; pe = z; end
      P_BN:  begin sa = 1; alu = 4'b0110; ps = 2'b01; pe = !z; end
      P_IX: begin
        sa = 1; sb = 2'b10;
        ze  = (o != 6'b001000);
        alu = (o == 6'b001100) ? 4'b0000 : (o == 6'b001101) ? 4'b0001 : 4'b0010;
      end
      P_IWB: rw = 1;
      P_J:   begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {io, mrd, mwr, irw, rd, m2r, rw, sa, sb, ze, alu, ps, pe, ill};
  endfunction

  function automatic logic pick_z(input int zmode);
    if (zmode == 0) return 1'b0;
    if (zmode == 1) return 1'b1;
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push_exp(input int ph);
    exp_t e;
    e.ph  = ph;
    e.ctl = (ph == P_RST) ? 19'd0 : exp_ctl(ph, op, funct, zero, mem_ready);
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // Drive one cycle's inputs (at posedge+1), record the expectation, advance
  task automatic cyc(input int ph, input logic mr, input logic z);
    mem_ready = mr;
    zero      = z;
    push_exp(ph);
    @(posedge clk);
    #1;
  endtask

  // Phase that waits for mem_ready; random mode forces ready after 6 misses
  task automatic wait_phase(input int ph, input bit rnd, input int nwait,
                            input int zmode);
    logic mr;
    for (int i = 0; i < 16; i++) begin
      if (rnd) mr = (i >= 6) || ($urandom_range(0, 2) != 0);
      else     mr = (i >= nwait);
      cyc(ph, mr, pick_z(zmode));
      if (mr) break;
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int zmode, input bit rnd, input int nwait);
    op    = o;
    funct = f;
    wait_phase(P_F, rnd, 0, zmode);
    cyc(P_D, logic'($urandom_range(0, 1)), pick_z(zmode));
    case (o)
      6'b100011: begin
        cyc(P_MA, logic'($urandom_range(0, 1)), pick_z(zmode));
        wait_phase(P_MR, rnd, nwait, zmode);
        cyc(P_MWB, logic'($urandom_range(0, 1)), pick_z(zmode));
        m_cnt = m_cnt + 1'b1;
      end
      6'b101011: begin
        cyc(P_MA, logic'($urandom_range(0, 1)), pick_z(zmode));
        wait_phase(P_MW, rnd, nwait, zmode);
        m_cnt = m_cnt + 1'b1;
      end
      6'b000000: begin
        cyc(P_RX, logic'($urandom_range(0, 1)), pick_z(zmode));
        cyc(P_RWB, logic'($urandom_range(0, 1)), pick_z(zmode));
        m_cnt = m_cnt + 1'b1;
      end
      6'b000100: begin
        cyc(P_BQ, logic'($urandom_range(0, 1)), pick_z(zmode));
        m_cnt = m_cnt + 1'b1;
      end
`ifdef BNE_EN
      6'b000101: begin
        cyc(P_BN, logic'($urandom_range(0, 1)), pick_z(zmode));
        m_cnt = m_cnt + 1'b1;
      end
`endif
      6'b001000, 6'b001100, 6'b001101: begin
        cyc(P_IX, logic'($urandom_range(0, 1)), pick_z(zmode));
        cyc(P_IWB, logic'($urandom_range(0, 1)), pick_z(zmode));
        m_cnt = m_cnt + 1'b1;
      end
      6'b000010: begin
        cyc(P_J, logic'($urandom_range(0, 1)), pick_z(zmode));
        m_cnt = m_cnt + 1'b1;
      end
      default: ;  // illegal: back to fetch, nothing retired
    endcase
  endtask

  // lw aborted by reset while waiting in the memory-read phase
  task automatic reset_in_memrd();
    op    = 6'b100011;
    funct = 6'd0;
    wait_phase(P_F, 1'b0, 0, 0);
    cyc(P_D, 1'b1, 1'b0);
    cyc(P_MA, 1'b1, 1'b0);
    mem_ready = 1'b0;
    push_exp(P_MR);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (act !== 19'd0 || retired_count !== '0) begin
      bad++;
      $display("FAIL async_reset got ctl=%h cnt=%0d want ctl=0 cnt=0",
               act, retired_count);
    end
    m_cnt = '0;
    @(posedge clk);
    #1;
    cyc(P_RST, 1'b1, 1'b1);
    cyc(P_RST, 1'b1, 1'b0);
    reset_n = 1'b1;
  endtask

  // Monitor: every cycle with a pending expectation is checked mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (act !== e.ctl || retired_count !== e.cnt) begin
          bad++;
          $display("FAIL ctl phase=%0d got ctl=%h cnt=%0d want ctl=%h cnt=%0d",
                   e.ph, act, retired_count, e.ctl, e.cnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [5:0] o, f;
    int         r;
    @(posedge clk);
    #1;
    cyc(P_RST, 1'b1, 1'b0);
    cyc(P_RST, 1'b1, 1'b1);
    reset_n = 1'b1;

    run_instr(6'b100011, 6'd0,      0, 1'b0, 0);  // lw, always ready
    run_instr(6'b101011, 6'd0,      0, 1'b0, 3);  // sw, 3 wait cycles
    run_instr(6'b000100, 6'd0,      1, 1'b0, 0);  // beq taken
    run_instr(6'b000100, 6'd0,      0, 1'b0, 0);  // beq not taken
    run_instr(6'b001101, 6'd0,      0, 1'b0, 0);  // ori
    run_instr(6'b000000, 6'b101010, 0, 1'b0, 0);  // slt
    run_instr(6'b111111, 6'd0,      0, 1'b0, 0);  // illegal
    run_instr(6'b000101, 6'd0,      0, 1'b0, 0);  // bne (illegal if disabled)
    reset_in_memrd();
    for (int i = 0; i < 17; i++) run_instr(6'b000010, 6'd0, 2, 1'b0, 0);

    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 11));
      case (r)
        0:       o = 6'b100011;
        1:       o = 6'b101011;
        2, 3:    o = 6'b000000;
        4:       o = 6'b000100;
        5:       o = 6'b000101;
        6:       o = 6'b001000;
        7:       o = 6'b001100;
        8:       o = 6'b001101;
        9:       o = 6'b000010;
        default: o = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 5))
        0:       f = 6'b100000;
        1:       f = 6'b100010;
        2:       f = 6'b100100;
        3:       f = 6'b100101;
        4:       f = 6'b101010;
        default: f = 6'($urandom_range(0, 63));
      endcase
      run_instr(o, f, 2, 1'b1, 0);
    end

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Next-generation MIPS control unit for the multicycle datapath: one shared memory, IR, ALUOut and register-file write-back spread over 3-5 cycles per instruction.
- Moore FSM driven by op/funct from the instruction register plus the ALU zero flag.
- Adds a memory ready handshake, a retired-instruction counter and illegal-opcode detection.
- Sits beside the multicycle datapath in the processor top, in place of the single-cycle controller.

Parameters:
- ALUCTRL_W, 3: alucontrol width; must be >=3; bits above [2:0] are driven 0.
- CNT_W, 32: width of retired_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  IR load enable.
- regdst  out  1  1 selects rd, 0 selects rt.
- memtoreg  out  1  write-back data select: 1 = MDR.
- regwrite  out  1  register-file write enable.
- alusrca  out  1  ALU A select: 0 = PC, 1 = A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- zeroext  out  1  zero-extend the immediate.
- alucontrol  out  ALUCTRL_W  ALU operation.
- pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump.
- pcen  out  1  PC write enable.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- retired_count  out  CNT_W  instructions completed.

Behaviour:
- Clock and reset are decided: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset: state = FETCH, retired_count = 0, illegal_op = 0. While reset_n = 0, every strobe (memread, memwrite, irwrite, regwrite, pcen) is forced to 0 and every select output is 0.
- Outputs are combinational from state (Moore). The exceptions are pcen and irwrite/pc update, which also depend on zero and mem_ready.
- ALU codes: add 010, sub 110, and 000, or 001, slt 111. Any output not listed for a state is 0.
- FETCH: memread = 1, iord = 0, alusrca = 0, alusrcb = 01, alu add.
  - mem_ready = 1: irwrite = 1, pcen = 1, pcsrc = 00, next DECODE.
  - mem_ready = 0: hold in FETCH, no writes.
- DECODE: alusrca = 0, alusrcb = 11, alu add. Next state by op:
  - 100011 / 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 / 001100 / 001101 -> IMMEX
  - 000010 -> JEX
  - any other op -> FETCH, with illegal_op = 1 for that cycle; not counted as retired.
- MEMADR: alusrca = 1, alusrcb = 10, add. Next MEMRD if op = lw, else MEMWR.
- MEMRD: iord = 1, memread = 1. Wait for mem_ready, then MEMWB.
- MEMWB: memtoreg = 1, regwrite = 1, regdst = 0. Next FETCH.
- MEMWR: iord = 1, memwrite = 1. Hold until mem_ready, then FETCH.
- RTYPEEX: alusrca = 1, alusrcb = 00. alucontrol from funct:
  - 100000 -> add, 100010 -> sub, 100100 -> and, 100101 -> or, 101010 -> slt
  - any other funct -> add
  - Next RTYPEWB.
- RTYPEWB: regdst = 1, regwrite = 1. Next FETCH.
- BEQEX: alusrca = 1, alusrcb = 00, sub, pcsrc = 01, pcen = zero. Next FETCH.
- IMMEX: alusrca = 1, alusrcb = 10.
  - addi: add, zeroext = 0.
  - andi: and, zeroext = 1.
  - ori: or, zeroext = 1.
  - Next IMMWB.
- IMMWB: regdst = 0, regwrite = 1. Next FETCH.
- JEX: pcsrc = 10, pcen = 1. Next FETCH.
- retired_count increments by 1 on every transition from MEMWB, MEMWR (with mem_ready), RTYPEWB, BEQEX, IMMWB or JEX into FETCH. It wraps from all-ones to 0.
- op and funct must stay stable from DECODE to write-back; IR is loaded only in FETCH.
- A mid-instruction reset aborts at once: no partial write, state = FETCH.

Optional Feature:
- Macro BNE_EN.
- Defined: op 000101 in DECODE -> BNEEX. BNEEX is identical to BEQEX except pcen = ~zero; it is counted as retired.
- Undefined: op 000101 is illegal and pulses illegal_op.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum statetype_e (FETCH..JEX, plus BNEEX);
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J;
  - funct constants;
  - ALU code constants.
- One sub-module, mc_aludec: combinational state/op/funct -> alucontrol.

Test Plan:
- lw, mem_ready high: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB (5 cycles). regwrite = 1 and memtoreg = 1 in cycle 5; retired_count 0 -> 1.
- sw with mem_ready low for 3 cycles in MEMWR: memwrite held 4 cycles, no state change, retired_count increments once.
- beq with zero = 1: pcen = 1 and pcsrc = 01 in BEQEX. With zero = 0: pcen = 0. Both take 3 cycles.
- ori then R-type funct 101010: zeroext = 1 with alucontrol = 001 in IMMEX; then alucontrol = 111 and regdst = 1 write-back.
- op 111111: illegal_op pulses for exactly 1 cycle in DECODE, next state FETCH, retired_count unchanged. With BNE_EN, op 000101 and zero = 0 gives pcen = 1.
- reset_n low during MEMRD: outputs go to 0 asynchronously and regwrite never asserts. After release, state is FETCH and retired_count = 0. Preloaded all-ones count wraps to 0 on the next retire.
